// File: rtl/rr_shared_reg_arbiter_if.sv
// rr_shared_reg_arbiter_if: requester bus and shared-register outputs for the round-robin register arbiter
interface rr_shared_reg_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int OW = $clog2(N);
    logic [N-1:0]   req;
    logic [N-1:0]   last;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [OW-1:0]  owner;
    logic           busy;
    logic [W-1:0]   q;
    logic           q_valid;
    modport master (output req, last, wdata, input gnt, owner, busy, q, q_valid);
    modport slave  (input req, last, wdata, output gnt, owner, busy, q, q_valid);
endinterface

// File: rtl/rr_shared_reg_arbiter.sv
// rr_shared_reg_arbiter: round-robin tenure arbiter writing one shared W-bit register
module rr_shared_reg_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input logic clk,
    input logic reset,
    rr_shared_reg_arbiter_if.slave bus
);
    localparam int OW = $clog2(N);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state, n_state;
    logic [N-1:0]  gnt, n_gnt;
    logic [OW-1:0] owner, n_owner, ptr, n_ptr;
    logic [CW-1:0] beat_cnt, n_cnt;
    logic [W-1:0]  q;
    logic          q_valid, beat, tend;
    logic [N-1:0]  m;

    // first requester after p, wrapping modulo N
    function automatic logic [OW-1:0] sel(input logic [N-1:0] v, input logic [OW-1:0] p);
        logic [OW-1:0] r;
        r = '0;
        for (int k = N; k >= 1; k--)
            if (v[(int'(p) + k) % N]) r = OW'((int'(p) + k) % N);
        return r;
    endfunction

    assign beat = (state == OWN) && bus.req[owner];
    assign tend = (state == OWN) && (!bus.req[owner] || bus.last[owner] || beat_cnt == CW'(MAX_HOLD - 1));
    assign m    = bus.req & ~(ONE << owner);

    always_comb begin
        n_state = state;
        n_gnt   = gnt;
        n_owner = owner;
        n_ptr   = ptr;
        n_cnt   = beat_cnt;
        if (state == IDLE) begin
            if (|bus.req) begin
                n_state = OWN;
                n_owner = sel(bus.req, ptr);
                n_gnt   = ONE << n_owner;
                n_cnt   = '0;
            end
        end else if (tend) begin
            n_ptr = owner;
            if (|m) begin
                n_owner = sel(m, owner);
                n_gnt   = ONE << n_owner;
                n_cnt   = '0;
            end else begin
                n_state = IDLE;
                n_gnt   = '0;
            end
        end else if (beat) begin
            n_cnt = beat_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            ptr      <= OW'(N - 1);
            beat_cnt <= '0;
            q        <= '0;
            q_valid  <= 1'b0;
        end else begin
            state    <= n_state;
            gnt      <= n_gnt;
            owner    <= n_owner;
            ptr      <= n_ptr;
            beat_cnt <= n_cnt;
            q_valid  <= beat;
            if (beat) q <= bus.wdata[owner*W +: W];
        end
    end

    assign bus.gnt     = gnt;
    assign bus.owner   = owner;
    assign bus.busy    = (state == OWN);
    assign bus.q       = q;
    assign bus.q_valid = q_valid;
endmodule

// File: tb/tb_rr_shared_reg_arbiter.sv
// tb_rr_shared_reg_arbiter: directed vectors with hand-computed expectations for rr_shared_reg_arbiter
module tb_rr_shared_reg_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    rr_shared_reg_arbiter_if #(.N(N), .W(W)) bus ();
    rr_shared_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic ck(input string tag, input logic [3:0] g, input logic [1:0] o, input logic b,
                      input logic [7:0] qq, input logic qv);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, ".owner"}, 32'(bus.owner), 32'(o));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
        chk({tag, ".q"}, 32'(bus.q), 32'(qq));
        chk({tag, ".q_valid"}, 32'(bus.q_valid), 32'(qv));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wd(input int i, input logic [7:0] v);
        bus.wdata[i*W +: W] = v;
    endtask

    task automatic do_reset();
        bus.req  = '0;
        bus.last = '0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.req = '0;
        bus.last = '0;
        bus.wdata = '0;
        #12;
        ck("rst", 4'b0000, 2'd0, 1'b0, 8'h00, 1'b0);
        tick();
        reset = 1'b0;

        // basic tenure, then wrap from ptr=2 to 3 and 0
        bus.req = 4'b0100;
        wd(2, 8'h11);
        tick(); ck("t1.grant", 4'b0100, 2'd2, 1'b1, 8'h00, 1'b0);
        tick(); ck("t1.b0", 4'b0100, 2'd2, 1'b1, 8'h11, 1'b1);
        wd(2, 8'h22);
        tick(); ck("t1.b1", 4'b0100, 2'd2, 1'b1, 8'h22, 1'b1);
        wd(2, 8'h33);
        bus.last = 4'b0100;
        tick(); ck("t1.b2", 4'b0000, 2'd2, 1'b0, 8'h33, 1'b1);
        bus.req = '0;
        bus.last = '0;
        tick(); ck("t1.idle", 4'b0000, 2'd2, 1'b0, 8'h33, 1'b0);
        bus.req = 4'b1001;
        tick(); ck("t1.wrap3", 4'b1000, 2'd3, 1'b1, 8'h33, 1'b0);
        bus.last = 4'b1000;
        wd(3, 8'h44);
        tick(); ck("t1.wrap0", 4'b0001, 2'd0, 1'b1, 8'h44, 1'b1);
        bus.req = 4'b0001;
        bus.last = 4'b0001;
        wd(0, 8'h55);
        tick(); ck("t1.end", 4'b0000, 2'd0, 1'b0, 8'h55, 1'b1);

        // all request, single-beat tenures, no bubbles
        do_reset();
        bus.req = 4'b1111;
        bus.last = 4'b1111;
        for (int i = 0; i < N; i++) wd(i, 8'(8'hB0 + i));
        tick(); ck("t2.g0", 4'b0001, 2'd0, 1'b1, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            ck($sformatf("t2.k%0d", k), 4'(1 << ((k + 1) % 4)), 2'((k + 1) % 4), 1'b1, 8'(8'hB0 + k), 1'b1);
        end

        // forced release with competitor, then alone with one bubble
        do_reset();
        bus.req = 4'b1010;
        wd(1, 8'hC0);
        tick(); ck("t3.grant", 4'b0010, 2'd1, 1'b1, 8'h00, 1'b0);
        for (int b = 0; b < 4; b++) begin
            tick();
            ck($sformatf("t3.b%0d", b), b == 3 ? 4'b1000 : 4'b0010, b == 3 ? 2'd3 : 2'd1, 1'b1, 8'(8'hC0 + b), 1'b1);
            wd(1, 8'(8'hC1 + b));
        end
        bus.req = 4'b0010;
        wd(1, 8'hE0);
        tick(); ck("t3.drop3", 4'b0010, 2'd1, 1'b1, 8'hC3, 1'b0);
        for (int b = 0; b < 4; b++) begin
            tick();
            ck($sformatf("t3.a%0d", b), b == 3 ? 4'b0000 : 4'b0010, 2'd1, b != 3, 8'(8'hE0 + b), 1'b1);
            wd(1, 8'(8'hE1 + b));
        end
        tick(); ck("t3.regrant", 4'b0010, 2'd1, 1'b1, 8'hE3, 1'b0);

        // drop without last hands off to pending requester
        do_reset();
        bus.req = 4'b0011;
        wd(0, 8'hA0);
        tick(); ck("t4.grant", 4'b0001, 2'd0, 1'b1, 8'h00, 1'b0);
        tick(); ck("t4.b0", 4'b0001, 2'd0, 1'b1, 8'hA0, 1'b1);
        wd(0, 8'hA1);
        tick(); ck("t4.b1", 4'b0001, 2'd0, 1'b1, 8'hA1, 1'b1);
        bus.req = 4'b0010;
        wd(0, 8'hA2);
        tick(); ck("t4.drop", 4'b0010, 2'd1, 1'b1, 8'hA1, 1'b0);

        // asynchronous reset in the middle of a tenure
        do_reset();
        bus.req = 4'b0100;
        wd(2, 8'h77);
        tick(); ck("t5.grant", 4'b0100, 2'd2, 1'b1, 8'h00, 1'b0);
        tick(); ck("t5.b0", 4'b0100, 2'd2, 1'b1, 8'h77, 1'b1);
        wd(2, 8'h78);
        #2 reset = 1'b1;
        #1 ck("t5.async", 4'b0000, 2'd0, 1'b0, 8'h00, 1'b0);
        bus.req = 4'b0110;
        #1 reset = 1'b0;
        tick(); ck("t5.resume", 4'b0010, 2'd1, 1'b1, 8'h00, 1'b0);

        // non-owner last/wdata and last-without-req are ignored
        bus.req = 4'b0010;
        wd(1, 8'hD0);
        for (int b = 0; b < 3; b++) begin
            bus.last = {b[0] ^ 1'b1, 1'b0, b == 2, 1'b0};
            wd(3, 8'(8'hF0 + b));
            tick();
            ck($sformatf("t6.b%0d", b), b == 2 ? 4'b0000 : 4'b0010, 2'd1, b != 2, 8'(8'hD0 + b), 1'b1);
            wd(1, 8'(8'hD1 + b));
        end
        bus.req = '0;
        bus.last = 4'b1000;
        tick(); ck("t6.idle", 4'b0000, 2'd1, 1'b0, 8'hD2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
